// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready command front-end that issues operands to the combinational ALU
// and returns its captured result. Optional overflow statistics: define ALU_SEQ_STICKY_FLAGS_EN.
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic [CTRL_W-1:0] cmd_ctrl,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_s,
    input  logic              alu_overflow,
    input  logic              alu_zero,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_s,
    output logic              rsp_overflow,
    output logic              rsp_zero,

    output logic              busy,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    input  logic              sticky_clr,
    output logic              ovf_sticky,
    output logic [7:0]        ovf_count,
`endif
    output logic [15:0]       op_count
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_op_sequencer: SETTLE must be within 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]    alu_a_q, alu_a_d;
    logic [WIDTH-1:0]    alu_b_q, alu_b_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_s_q, rsp_s_d;
    logic                rsp_ovf_q, rsp_ovf_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic [15:0]         op_count_q, op_count_d;
    logic                cmd_accept;
    logic                rsp_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_zero_q  <= rsp_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_s_d     = rsp_s_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_zero_d  = rsp_zero_q;
        cmd_ready   = 1'b0;
        rsp_hs      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_WAIT: begin
                // Counter value 1 marks the SETTLE-th edge after accept.
                if (cnt_q == 4'd1) begin
                    rsp_s_d     = alu_s;
                    rsp_ovf_d   = alu_overflow;
                    rsp_zero_d  = alu_zero;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                cmd_ready = rsp_ready;
                if (rsp_valid_q && rsp_ready) begin
                    rsp_hs      = 1'b1;
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An accept in RESP overrides the return to IDLE, giving back-to-back issue.
        cmd_accept = cmd_valid && cmd_ready;
        if (cmd_accept) begin
            alu_a_d    = cmd_a;
            alu_b_d    = cmd_b;
            alu_ctrl_d = cmd_ctrl;
            cnt_d      = 4'(SETTLE);
            state_d    = ST_WAIT;
        end

        op_count_d = rsp_hs ? op_count_q + 16'd1 : op_count_q;
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic       ovf_sticky_q, ovf_sticky_d;
    logic [7:0] ovf_count_q, ovf_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        ovf_count_d  = ovf_count_q;
        if (sticky_clr) begin
            ovf_sticky_d = 1'b0;
            ovf_count_d  = '0;
        end else if (rsp_hs && rsp_ovf_q) begin
            ovf_sticky_d = 1'b1;
            if (ovf_count_q != 8'hFF) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end
    end

    assign ovf_sticky = ovf_sticky_q;
    assign ovf_count  = ovf_count_q;
`endif

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_s        = rsp_s_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_zero     = rsp_zero_q;
    assign busy         = (state_q != ST_IDLE);
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a combinational adder standing in for the ALU.
module tb_alu_op_sequencer;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_a = '0;
    logic [WIDTH-1:0]  cmd_b = '0;
    logic [CTRL_W-1:0] cmd_ctrl = '0;
    logic [WIDTH-1:0]  alu_a, alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_s;
    logic              alu_overflow, alu_zero;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [WIDTH-1:0]  rsp_s;
    logic              rsp_overflow, rsp_zero;
    logic              busy;
    logic [15:0]       op_count;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic              sticky_clr = 1'b0;
    logic              ovf_sticky;
    logic [7:0]        ovf_count;
`endif

    always #5 clk = ~clk;

    assign alu_s        = alu_a + alu_b;
    assign alu_overflow = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
    assign alu_zero     = (alu_s == '0);

    alu_op_sequencer #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_ctrl     (cmd_ctrl),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_s        (alu_s),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_s        (rsp_s),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .busy         (busy),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        .sticky_clr   (sticky_clr),
        .ovf_sticky   (ovf_sticky),
        .ovf_count    (ovf_count),
`endif
        .op_count     (op_count)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        ovf;
        logic        zero;
    } rsp_t;

    rsp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [15:0] tab_a [4] = '{16'h7FFF, 16'hFFFF, 16'h1234, 16'h8000};
    logic [15:0] tab_b [4] = '{16'h0001, 16'h0001, 16'h4321, 16'h8000};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference built from signed integer arithmetic rather than bit tricks.
    function automatic rsp_t model(input logic [15:0] a, input logic [15:0] b);
        rsp_t r;
        int   sa;
        sa     = int'($signed(a)) + int'($signed(b));
        r.s    = 16'(a + b);
        r.ovf  = (sa > 32767) || (sa < -32768);
        r.zero = (r.s == 16'h0000);
        return r;
    endfunction

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c);
        int n;
        cmd_a     = a;
        cmd_b     = b;
        cmd_ctrl  = c;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        exp_q.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic compare_rsp(input string tag);
        rsp_t e;
        check_val({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_size"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_s"},    32'(rsp_s),        32'(e.s));
            check_val({tag, "_ovf"},  32'(rsp_overflow), 32'(e.ovf));
            check_val({tag, "_zero"}, 32'(rsp_zero),     32'(e.zero));
        end
    endtask

    task automatic take_rsp(input string tag);
        compare_rsp(tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rsp_t e;

        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_busy",      32'(busy),      32'd0);
        check_val("rst_alu_a",     32'(alu_a),     32'd0);
        check_val("rst_alu_ctrl",  32'(alu_ctrl),  32'd0);
        check_val("rst_rsp_s",     32'(rsp_s),     32'd0);
        check_val("rst_op_count",  32'(op_count),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic op and latency
        issue(16'h0003, 16'h0004, 4'h2);
        check_val("t1_alu_a",     32'(alu_a),     32'h3);
        check_val("t1_alu_b",     32'(alu_b),     32'h4);
        check_val("t1_alu_ctrl",  32'(alu_ctrl),  32'h2);
        check_val("t1_busy",      32'(busy),      32'd1);
        check_val("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        wait_rsp(lat);
        check_val("t1_latency", 32'(lat), 32'(SETTLE));
        take_rsp("t1");
        check_val("t1_op_count",  32'(op_count),  32'd1);
        check_val("t1_rsp_drop",  32'(rsp_valid), 32'd0);
        check_val("t1_idle",      32'(busy),      32'd0);

        // Overflow / zero / plain / overflow-to-zero patterns
        for (int i = 0; i < 4; i++) begin
            issue(tab_a[i], tab_b[i], 4'(i));
            wait_rsp(lat);
            check_val("t2_latency", 32'(lat), 32'(SETTLE));
            take_rsp("t2");
        end
        check_val("t2_op_count", 32'(op_count), 32'd5);

        // Backpressure with a second command pending
        issue(16'h0100, 16'h0020, 4'h3);
        wait_rsp(lat);
        check_val("t3_latency", 32'(lat), 32'(SETTLE));
        cmd_a     = 16'h0BAD;
        cmd_b     = 16'h0011;
        cmd_ctrl  = 4'h5;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val("t3_hold_valid", 32'(rsp_valid), 32'd1);
            check_val("t3_hold_s",     32'(rsp_s),     32'h0120);
            check_val("t3_cmd_ready",  32'(cmd_ready), 32'd0);
            check_val("t3_alu_a",      32'(alu_a),     32'h0100);
            check_val("t3_alu_ctrl",   32'(alu_ctrl),  32'h3);
            @(negedge clk);
        end
        compare_rsp("t3_first");
        rsp_ready = 1'b1;
        #1;
        check_val("t3_ready_comb", 32'(cmd_ready), 32'd1);
        exp_q.push_back(model(16'h0BAD, 16'h0011));
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check_val("t3_b2b_valid", 32'(rsp_valid), 32'd0);
        check_val("t3_b2b_busy",  32'(busy),      32'd1);
        check_val("t3_b2b_alu_a", 32'(alu_a),     32'h0BAD);
        check_val("t3_b2b_count", 32'(op_count),  32'd6);
        wait_rsp(lat);
        check_val("t3_b2b_latency", 32'(lat), 32'(SETTLE));
        take_rsp("t3_second");
        check_val("t3_op_count", 32'(op_count), 32'd7);

        // Asynchronous reset during WAIT
        issue(16'h1111, 16'h2222, 4'h1);
        rst_n = 1'b0;
        #1;
        check_val("t4_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("t4_alu_a",     32'(alu_a),     32'd0);
        check_val("t4_alu_b",     32'(alu_b),     32'd0);
        check_val("t4_op_count",  32'(op_count),  32'd0);
        check_val("t4_busy",      32'(busy),      32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h0005, 16'h0006, 4'h0);
        wait_rsp(lat);
        check_val("t4_latency", 32'(lat), 32'(SETTLE));
        take_rsp("t4");
        check_val("t4_op_count_after", 32'(op_count), 32'd1);

        // op_count wrap from a preloaded value
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.op_count_q;
        @(negedge clk);
        check_val("t5_preload", 32'(op_count), 32'hFFFF);
        issue(16'h0001, 16'h0002, 4'h0);
        wait_rsp(lat);
        take_rsp("t5");
        check_val("t5_wrap", 32'(op_count), 32'h0000);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
        check_val("t6_count_start", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            issue(16'h4000, 16'h4000, 4'h0);
            wait_rsp(lat);
            take_rsp("t6");
        end
        check_val("t6_ovf_count",  32'(ovf_count),  32'd3);
        check_val("t6_ovf_sticky", 32'(ovf_sticky), 32'd1);
        issue(16'h4000, 16'h4000, 4'h0);
        wait_rsp(lat);
        sticky_clr = 1'b1;
        take_rsp("t6_clr");
        sticky_clr = 1'b0;
        check_val("t6_clr_count",  32'(ovf_count),  32'd0);
        check_val("t6_clr_sticky", 32'(ovf_sticky), 32'd0);
`endif

        e = '0;
        check_val("sb_leftover", 32'(exp_q.size()), 32'(e.s));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
